mux_axistream_arbiter: RTL and testbench

MUX_AXISTREAM_ARBITER -- requirements
Module: mux_axistream_arbiter

---
 rtl/mux_axistream_arbiter.sv | 107 ++++++++++
 tb/tb_mux_axistream_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_axistream_arbiter.sv
// Round-robin N:1 AXI-Stream packet arbiter.
// A source owns the merged stream until its tlast beat completes.
module mux_axistream_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_SRC    = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_SRC-1:0]            src_tvalid,
  output logic [NUM_SRC-1:0]            src_tready,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] src_tdata,
  input  logic [NUM_SRC-1:0]            src_tlast,
  output logic                          dest_tvalid,
  input  logic                          dest_tready,
  output logic [DATA_WIDTH-1:0]         dest_tdata,
  output logic                          dest_tlast,
  output logic [NUM_SRC-1:0]            grant,
  output logic                          busy
);

  localparam int IW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic [IW-1:0] owner_q;
  logic [IW-1:0] owner_d;
  logic [IW-1:0] last_q;
  logic [IW-1:0] last_d;
  logic [IW-1:0] pick;
  logic [IW:0]   cand;
  logic          found;

  // Round-robin search starting just after the last granted source.
  // The extra bit in cand lets the wrap work for non power-of-2 counts.
  always_comb begin
    pick  = last_q;
    found = 1'b0;
    cand  = '0;
    for (int i = 1; i <= NUM_SRC; i++) begin
      cand = {1'b0, last_q} + (IW+1)'(i);
      if (cand >= (IW+1)'(NUM_SRC)) begin
        cand = cand - (IW+1)'(NUM_SRC);
      end
      if (!found && src_tvalid[cand[IW-1:0]]) begin
        found = 1'b1;
        pick  = cand[IW-1:0];
      end
    end
  end

  // Next-state logic plus the zero-latency data path for the owner.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    dest_tvalid = 1'b0;
    dest_tdata  = '0;
    dest_tlast  = 1'b0;
    src_tready  = '0;
    grant       = '0;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          owner_d = pick;
          state_d = BUSY;
        end
      end
      BUSY: begin
        dest_tvalid         = src_tvalid[owner_q];
        dest_tdata          = src_tdata[int'(owner_q)*DATA_WIDTH +: DATA_WIDTH];
        dest_tlast          = src_tlast[owner_q];
        src_tready[owner_q] = dest_tready;
        grant[owner_q]      = 1'b1;
        if (dest_tvalid && dest_tready && dest_tlast) begin
          last_d  = owner_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (rst) begin
      dest_tvalid = 1'b0;
      src_tready  = '0;
    end
  end

  // State, owner and round-robin pointer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q  <= IW'(NUM_SRC - 1);
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

  assign busy = (state_q == BUSY);

endmodule

// File: tb/tb_mux_axistream_arbiter.sv
// Scoreboard bench for mux_axistream_arbiter.
// Directed packet scenarios followed by randomized traffic.
`timescale 1ns/1ps
module tb_mux_axistream_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    src_tvalid;
  logic [N-1:0]    src_tready;
  logic [N*DW-1:0] src_tdata;
  logic [N-1:0]    src_tlast;
  logic            dest_tvalid;
  logic            dest_tready;
  logic [DW-1:0]   dest_tdata;
  logic            dest_tlast;
  logic [N-1:0]    grant;
  logic            busy;

  mux_axistream_arbiter #(
    .DATA_WIDTH(DW),
    .NUM_SRC   (N)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .src_tvalid (src_tvalid),
    .src_tready (src_tready),
    .src_tdata  (src_tdata),
    .src_tlast  (src_tlast),
    .dest_tvalid(dest_tvalid),
    .dest_tready(dest_tready),
    .dest_tdata (dest_tdata),
    .dest_tlast (dest_tlast),
    .grant      (grant),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          l;
  } beat_t;

  beat_t txq[N][$];
  beat_t expq[N][$];
  int    gap[N] = '{default: 0};
  logic [N-1:0] hs = '0;
  int    total = 0;
  int    bad = 0;
  int    glog[$];
  bit    m_idle;
  int    m_owner;
  int    m_last;
  bit    have_prev;
  logic [DW-1:0] prev_d;
  beat_t e_b;
  bit    m_found;
  int    rr_exp[5] = '{0, 1, 2, 3, 0};
  int    rk;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic bit all_empty();
    for (int k = 0; k < N; k++) begin
      if (expq[k].size() != 0) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic push_pkt(input int k, input int len, input int d0,
                          input int step);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.d = DW'(d0 + i * step);
      b.l = (i == len - 1);
      txq[k].push_back(b);
      expq[k].push_back(b);
    end
  endtask

  task automatic drain(input int budget, input string name);
    int n;
    n = 0;
    while (!(all_empty() && m_idle) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    chk(name, all_empty() && m_idle, 1);
    @(posedge clk); #1;
  endtask

  task automatic wait_exp(input int k, input int sz, input string name);
    int n;
    n = 0;
    while (expq[k].size() != sz && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk(name, expq[k].size(), sz);
  endtask

  // Source drivers: present queue fronts, pop on completed handshakes.
  initial begin
    src_tvalid = '0;
    src_tdata  = '0;
    src_tlast  = '0;
    forever begin
      @(posedge clk); #2;
      for (int k = 0; k < N; k++) begin
        if (hs[k] && txq[k].size() > 0) txq[k].delete(0);
        if (gap[k] > 0) begin
          gap[k]--;
          src_tvalid[k] = 1'b0;
        end else if (txq[k].size() > 0) begin
          src_tvalid[k]           = 1'b1;
          src_tdata[k*DW +: DW]   = txq[k][0].d;
          src_tlast[k]            = txq[k][0].l;
        end else begin
          src_tvalid[k] = 1'b0;
          src_tlast[k]  = 1'b0;
        end
      end
    end
  end

  // Monitor with a packet-level arbitration model and scoreboard.
  initial begin
    m_idle    = 1'b1;
    m_last    = N - 1;
    m_owner   = 0;
    have_prev = 1'b0;
    forever begin
      @(negedge clk);
      hs = src_tvalid & src_tready;
      if (rst) begin
        chk("rst_dest_tvalid", dest_tvalid, 0);
        chk("rst_src_tready", src_tready, 0);
        m_idle    = 1'b1;
        m_last    = N - 1;
        have_prev = 1'b0;
      end else begin
        chk("grant_onehot", $countones(grant) <= 1, 1);
        if (dest_tvalid && dest_tready) begin
          chk("one_src_hs", $countones(src_tvalid & src_tready), 1);
        end
        if (m_idle) begin
          chk("idle_grant", grant, 0);
          chk("idle_busy", busy, 0);
          chk("idle_dvalid", dest_tvalid, 0);
          chk("idle_sready", src_tready, 0);
          have_prev = 1'b0;
          m_found   = 1'b0;
          for (int i = 1; i <= N; i++) begin
            if (!m_found && src_tvalid[(m_last + i) % N]) begin
              m_found = 1'b1;
              m_owner = (m_last + i) % N;
            end
          end
          if (m_found) begin
            m_idle = 1'b0;
            glog.push_back(m_owner);
          end
        end else begin
          chk("busy", busy, 1);
          chk("grant", grant, 1 << m_owner);
          chk("dvalid", dest_tvalid, src_tvalid[m_owner]);
          chk("sready", src_tready, dest_tready ? (1 << m_owner) : 0);
          if (dest_tvalid) begin
            chk("ddata", dest_tdata, src_tdata[m_owner*DW +: DW]);
            chk("dlast", dest_tlast, src_tlast[m_owner]);
          end
          if (have_prev && dest_tvalid) chk("stall_hold", dest_tdata, prev_d);
          have_prev = dest_tvalid && !dest_tready;
          prev_d    = dest_tdata;
          if (dest_tvalid && dest_tready) begin
            chk("sb_nonempty", expq[m_owner].size() > 0, 1);
            if (expq[m_owner].size() > 0) begin
              e_b = expq[m_owner].pop_front();
              chk("sb_data", dest_tdata, e_b.d);
              chk("sb_last", dest_tlast, e_b.l);
            end
            if (dest_tlast) begin
              m_last    = m_owner;
              m_idle    = 1'b1;
              have_prev = 1'b0;
            end
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    dest_tready = 1'b1;
    rst         = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // All four sources request continuously, two-beat packets.
    glog.delete();
    for (int k = 0; k < N; k++) begin
      push_pkt(k, 2, k * 16, 1);
      push_pkt(k, 2, k * 16 + 8, 1);
    end
    drain(200, "rr_drain");
    for (int i = 0; i < 5; i++) begin
      chk("rr_order", (i < glog.size()) ? glog[i] : -1, rr_exp[i]);
    end

    // Single source 2, three beats.
    glog.delete();
    push_pkt(2, 3, 'h11, 'h11);
    drain(100, "src2_drain");
    chk("src2_owner", (glog.size() > 0) ? glog[0] : -1, 2);

    // Backpressure for five cycles mid-packet.
    push_pkt(1, 6, 'h40, 3);
    wait_exp(1, 4, "stall_start");
    dest_tready = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
    end
    chk("stall_no_loss", expq[1].size(), 4);
    chk("stall_owner", grant, 4'b0010);
    dest_tready = 1'b1;
    drain(100, "stall_drain");

    // Owner 1 drops tvalid while source 0 waits.
    glog.delete();
    push_pkt(1, 5, 'h60, 1);
    wait_exp(1, 5, "drop_queued");
    while (glog.size() == 0 && !rst) begin
      @(posedge clk); #1;
      if (expq[1].size() < 5) break;
    end
    push_pkt(0, 2, 'h70, 1);
    wait_exp(1, 3, "drop_start");
    gap[1] = 3;
    repeat (3) begin
      @(posedge clk); #1;
      chk("drop_owner", grant, 4'b0010);
    end
    drain(100, "drop_drain");
    chk("drop_first", (glog.size() > 0) ? glog[0] : -1, 1);
    chk("drop_second", (glog.size() > 1) ? glog[1] : -1, 0);

    // Reset during beat two of a four-beat packet.
    push_pkt(3, 4, 'h80, 1);
    wait_exp(3, 3, "rst_start");
    rst = 1'b1;
    for (int k = 0; k < N; k++) begin
      txq[k].delete();
      expq[k].delete();
      gap[k] = 0;
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    glog.delete();
    push_pkt(2, 2, 'h90, 1);
    push_pkt(1, 2, 'hA0, 1);
    drain(100, "rst_drain");
    chk("rst_first", (glog.size() > 0) ? glog[0] : -1, 1);
    chk("rst_second", (glog.size() > 1) ? glog[1] : -1, 2);

    // Randomized traffic, backpressure and valid gaps.
    for (int c = 0; c < 1500; c++) begin
      @(posedge clk); #1;
      dest_tready = ($urandom_range(3) != 0);
      if ($urandom_range(5) == 0) begin
        rk = $urandom_range(N - 1);
        if (txq[rk].size() < 8) begin
          push_pkt(rk, $urandom_range(1, 4), $urandom, $urandom);
        end
      end
      if ($urandom_range(31) == 0) begin
        gap[$urandom_range(N - 1)] = $urandom_range(1, 3);
      end
    end
    dest_tready = 1'b1;
    drain(3000, "rand_drain");
    chk("final_empty", all_empty(), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
